// File: rtl/rv32im_ctrl_pkg.sv
// Shared definitions for the RV32IM pipeline control block:
// FSM encodings, parameter defaults, NOP encoding and the control-output bundle.
package rv32im_ctrl_pkg;

  localparam int          CNT_W_DEF      = 16;
  localparam int          MD_TIMEOUT_DEF = 64;

  // addi x0, x0, 0 -- what a flushed/bubbled register holds.
  localparam logic [31:0] NOP_INSN       = 32'h0000_0013;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_e;

  // Pipeline register controls, one bundle so defaults and overrides stay in one place.
  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_bubble;
    logic md_start;
  } ctrl_t;

  // Everything advances, nothing squashed.
  localparam ctrl_t CTRL_DEFAULT = 8'b1111_0000;
  // Held in reset: nothing loads, every register forced to NOP.
  localparam ctrl_t CTRL_RESET   = 8'b0000_1110;
  // Front end and the MD instruction in EX held; EX_MEM fills with a bubble.
  localparam ctrl_t CTRL_FREEZE  = 8'b0001_0010;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, sticking at all ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: load-use stalls, branch redirect flushes,
// and the start/done handshake with the multi-cycle M-extension unit.
module pipeline_hazard_ctrl
  import rv32im_ctrl_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_select,
  input  logic             ex_md_op,
  input  logic             md_done,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             id_ex_write_en,
  output logic             ex_mem_write_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             md_start,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             md_err
);

  localparam int WC_W = $clog2(MD_TIMEOUT + 1);

  state_e          state;
  logic [WC_W-1:0] wait_cnt;
  logic            lu;
  logic            md_tmo;
  logic            stall_inc;
  logic            flush_inc;
  ctrl_t           ctl;

  // Load-use: a load in EX writes a register the ID instruction reads (x0 exempt).
  always_comb begin
    lu = ex_mem_read && (ex_rd != 5'd0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  end

  assign md_tmo = (wait_cnt == WC_W'(MD_TIMEOUT));

  // Combinational control decode from state and current inputs; reset overrides all.
  always_comb begin
    ctl       = CTRL_DEFAULT;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (ex_md_op) begin
          // The start cycle is itself a stall cycle.
          ctl          = CTRL_FREEZE;
          ctl.md_start = 1'b1;
          stall_inc    = 1'b1;
        end else if (ex_branch_select) begin
          ctl.if_id_flush = 1'b1;
          ctl.id_ex_flush = 1'b1;
          flush_inc       = 1'b1;
        end else if (lu) begin
          ctl.pc_we       = 1'b0;
          ctl.if_id_we    = 1'b0;
          ctl.id_ex_flush = 1'b1;
          stall_inc       = 1'b1;
        end
      end
      ST_MD_WAIT: begin
        // Release (done or timeout) uses default outputs so EX_MEM captures the result.
        if (!md_done && !md_tmo) begin
          ctl       = CTRL_FREEZE;
          stall_inc = 1'b1;
        end
      end
      default: ctl = CTRL_DEFAULT;
    endcase
    if (!rst_n) begin
      ctl       = CTRL_RESET;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
    end
  end

  assign pc_write_en     = ctl.pc_we;
  assign if_id_write_en  = ctl.if_id_we;
  assign id_ex_write_en  = ctl.id_ex_we;
  assign ex_mem_write_en = ctl.ex_mem_we;
  assign if_id_flush     = ctl.if_id_flush;
  assign id_ex_flush     = ctl.id_ex_flush;
  assign ex_mem_bubble   = ctl.ex_mem_bubble;
  assign md_start        = ctl.md_start;

  // MD handshake FSM with wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      md_err   <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (ex_md_op) begin
            state    <= ST_MD_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_MD_WAIT: begin
          if (md_done) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (md_tmo) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            md_err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (CNT_W=4, MD_TIMEOUT=8).
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int MD_TO = 8;

  // {pc, if_id, id_ex, ex_mem write-enables, if_id_flush, id_ex_flush, bubble, md_start}
  localparam logic [7:0] E_DEF = 8'b1111_0000;
  localparam logic [7:0] E_LU  = 8'b0011_0100;
  localparam logic [7:0] E_BR  = 8'b1111_1100;
  localparam logic [7:0] E_FRZ = 8'b0001_0010;
  localparam logic [7:0] E_STR = 8'b0001_0011;
  localparam logic [7:0] E_RST = 8'b0000_1110;

  typedef struct {
    string       nm;
    logic [16:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_select, ex_md_op, md_done;
  logic pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en;
  logic if_id_flush, id_ex_flush, ex_mem_bubble, md_start, md_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MD_TIMEOUT(MD_TO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_uses_rs1      (id_uses_rs1),
    .id_uses_rs2      (id_uses_rs2),
    .ex_rd            (ex_rd),
    .ex_mem_read      (ex_mem_read),
    .ex_branch_select (ex_branch_select),
    .ex_md_op         (ex_md_op),
    .md_done          (md_done),
    .pc_write_en      (pc_write_en),
    .if_id_write_en   (if_id_write_en),
    .id_ex_write_en   (id_ex_write_en),
    .ex_mem_write_en  (ex_mem_write_en),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .ex_mem_bubble    (ex_mem_bubble),
    .md_start         (md_start),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt),
    .md_err           (md_err)
  );

  always #5 clk = ~clk;

  // Monitor: compare DUT outputs against the oldest expectation mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [16:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
             if_id_flush, id_ex_flush, ex_mem_bubble, md_start,
             stall_cnt, flush_cnt, md_err};
      n_chk++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got ctl=%b stall=%0d flush=%0d err=%b, want ctl=%b stall=%0d flush=%0d err=%b",
                 e.nm, act[16:9], act[8:5], act[4:1], act[0],
                 e.v[16:9], e.v[8:5], e.v[4:1], e.v[0]);
      end
    end
  end

  task automatic set_in(input logic md, input logic br, input logic mr, input logic [4:0] rd,
                        input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                        input logic u2, input logic dn);
    ex_md_op = md; ex_branch_select = br; ex_mem_read = mr; ex_rd = rd;
    id_rs1 = r1; id_uses_rs1 = u1; id_rs2 = r2; id_uses_rs2 = u2; md_done = dn;
  endtask

  // Queue the expected response for the current cycle, then advance one cycle.
  task automatic cyc(input string nm, input logic [7:0] c, input int st, input int fl,
                     input logic err);
    exp_t e;
    e.nm = nm;
    e.v  = {c, st[3:0], fl[3:0], err};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    cyc("reset_state", E_RST, 0, 0, 0);
    rst_n = 1'b1;
    cyc("idle", E_DEF, 0, 0, 0);

    // Load-use on rs1, then x0 never hazards, then rs2 and an unused rs2.
    set_in(0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0);
    cyc("lu_rs1", E_LU, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("lu_release", E_DEF, 1, 0, 0);
    set_in(0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0);
    cyc("lu_x0", E_DEF, 1, 0, 0);
    set_in(0, 0, 1, 5'd7, 5'd5, 0, 5'd7, 1, 0);
    cyc("lu_rs2", E_LU, 1, 0, 0);
    set_in(0, 0, 1, 5'd7, 5'd5, 1, 5'd7, 0, 0);
    cyc("lu_rs2_unused", E_DEF, 2, 0, 0);

    // Branch beats a simultaneous load-use.
    set_in(0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0);
    cyc("branch_over_lu", E_BR, 2, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("branch_after", E_DEF, 2, 1, 0);

    // MD op: start + 4 waiting cycles, then done.
    rst_n = 1'b0;
    cyc("reset2", E_RST, 0, 0, 0);
    rst_n = 1'b1;
    set_in(1, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0);
    cyc("md_start", E_STR, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cyc("md_wait", E_FRZ, i, 0, 0);
    md_done = 1'b1;
    cyc("md_done", E_DEF, 5, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("md_after", E_DEF, 5, 0, 0);

    // Back-to-back MD ops: second starts the cycle after release.
    ex_md_op = 1'b1;
    cyc("b2b_start1", E_STR, 5, 0, 0);
    md_done = 1'b1;
    cyc("b2b_done1", E_DEF, 6, 0, 0);
    md_done = 1'b0;
    cyc("b2b_start2", E_STR, 6, 0, 0);
    md_done = 1'b1;
    cyc("b2b_done2", E_DEF, 7, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("b2b_after", E_DEF, 7, 0, 0);

    // Timeout: 8 frozen wait cycles, abort cycle, sticky MD_ERR.
    rst_n = 1'b0;
    cyc("reset3", E_RST, 0, 0, 0);
    rst_n = 1'b1;
    ex_md_op = 1'b1;
    cyc("tmo_start", E_STR, 0, 0, 0);
    for (int i = 1; i <= MD_TO; i++) cyc("tmo_wait", E_FRZ, i, 0, 0);
    cyc("tmo_abort", E_DEF, 9, 0, 0);
    ex_md_op = 1'b0;
    cyc("tmo_err_set", E_DEF, 9, 0, 1);
    cyc("tmo_err_sticky", E_DEF, 9, 0, 1);

    // Reset asserted mid-wait.
    ex_md_op = 1'b1;
    cyc("rstw_start", E_STR, 9, 0, 1);
    cyc("rstw_wait1", E_FRZ, 10, 0, 1);
    cyc("rstw_wait2", E_FRZ, 11, 0, 1);
    rst_n = 1'b0;
    ex_md_op = 1'b0;
    cyc("rstw_low", E_RST, 0, 0, 0);
    rst_n = 1'b1;
    cyc("rstw_run", E_DEF, 0, 0, 0);
    set_in(0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0);
    cyc("rstw_lu", E_LU, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rstw_lu_after", E_DEF, 1, 0, 0);

    // Saturation: 20 consecutive load-use stalls, counter sticks at 15.
    set_in(0, 0, 1, 5'd9, 5'd9, 1, 5'd0, 0, 0);
    for (int i = 0; i < 20; i++) cyc("sat_lu", E_LU, (1 + i > 15) ? 15 : 1 + i, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("sat_hold", E_DEF, 15, 0, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
